// File: rtl/fft16_pkg.sv
// Shared constants and state encoding for the 16-point radix-2 DIF FFT sequencer.
package fft16_pkg;

    localparam int FFT_N       = 16;
    localparam int FFT_LOG2N   = 4;
    localparam int FFT_NBF     = 8;

    localparam int FFT_ADDR_W  = 4;
    localparam int FFT_TW_W    = 3;
    localparam int FFT_STAGE_W = 2;
    localparam int FFT_K_W     = 3;
    localparam int FFT_DCNT_W  = 4;

    typedef logic [1:0] agu_state_t;

    localparam agu_state_t ST_IDLE  = 2'd0;
    localparam agu_state_t ST_RUN   = 2'd1;
    localparam agu_state_t ST_DRAIN = 2'd2;
    localparam agu_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/fft16_bf_addr.sv
// Combinational butterfly address map: (stage, k) -> upper/lower data address and twiddle index.
module fft16_bf_addr
    import fft16_pkg::*;
(
    input  logic [FFT_STAGE_W-1:0] stage,
    input  logic [FFT_K_W-1:0]     k,
    output logic [FFT_ADDR_W-1:0]  addr_a,
    output logic [FFT_ADDR_W-1:0]  addr_b,
    output logic [FFT_TW_W-1:0]    tw_addr
);

    logic [FFT_ADDR_W-1:0] span;
    logic [FFT_ADDR_W-1:0] j;
    logic [FFT_ADDR_W-1:0] grp_base;

    // Group base is grp*2*span, i.e. the high k bits moved up past the span bit.
    always_comb begin
        span     = FFT_ADDR_W'(FFT_N / 2) >> stage;
        j        = {1'b0, k} & (span - FFT_ADDR_W'(1));
        grp_base = ({1'b0, k} >> (2'd3 - stage)) << (3'd4 - {1'b0, stage});
        addr_a   = grp_base | j;
        addr_b   = addr_a + span;
        tw_addr  = FFT_TW_W'(j << stage);
    end

endmodule

// File: rtl/fft16_agu.sv
// Sequencer for the in-place 16-point DIF FFT: walks 4 stages x 8 butterflies with a drain barrier.
// Optional macro FFT16_AGU_INVERSE_EN adds the inverse input and tw_conj output.
module fft16_agu
    import fft16_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int ADDR_W       = FFT_ADDR_W,
    parameter int TW_W         = FFT_TW_W
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef FFT16_AGU_INVERSE_EN
    input  logic              inverse,
    output logic              tw_conj,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [TW_W-1:0]   tw_addr,
    output logic [1:0]        stage,
    output logic              stage_last,
    input  logic              pipe_empty
);

    localparam logic [FFT_K_W-1:0]     K_LAST     = FFT_K_W'(FFT_NBF - 1);
    localparam logic [FFT_STAGE_W-1:0] STAGE_LAST = FFT_STAGE_W'(FFT_LOG2N - 1);
    localparam logic [FFT_DCNT_W-1:0]  DRAIN_LAST = FFT_DCNT_W'(DRAIN_CYCLES - 1);

    agu_state_t             state_q, state_d;
    logic [FFT_STAGE_W-1:0] stage_q, stage_d;
    logic [FFT_K_W-1:0]     k_q, k_d;
    logic [FFT_DCNT_W-1:0]  cnt_q, cnt_d;

    logic [FFT_ADDR_W-1:0]  map_a, map_b;
    logic [FFT_TW_W-1:0]    map_tw;
    logic                   run;

`ifdef FFT16_AGU_INVERSE_EN
    logic inv_q, inv_d;
`endif

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
`ifdef FFT16_AGU_INVERSE_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    k_d     = '0;
`ifdef FFT16_AGU_INVERSE_EN
                    inv_d   = inverse;
`endif
                end
            end
            ST_RUN: begin
                if (bf_ready) begin
                    k_d = k_q + FFT_K_W'(1);
                    if (k_q == K_LAST) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                // Counter parks at its terminal value so a late pipe_empty still releases the barrier.
                if (cnt_q != DRAIN_LAST) begin
                    cnt_d = cnt_q + FFT_DCNT_W'(1);
                end
                if (cnt_q == DRAIN_LAST && pipe_empty) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + FFT_STAGE_W'(1);
                        k_d     = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
`ifdef FFT16_AGU_INVERSE_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
`ifdef FFT16_AGU_INVERSE_EN
            inv_q   <= inv_d;
`endif
        end
    end

    fft16_bf_addr u_bf_addr (
        .stage   (stage_q),
        .k       (k_q),
        .addr_a  (map_a),
        .addr_b  (map_b),
        .tw_addr (map_tw)
    );

    // Descriptor fields come straight from registered stage/k, so they hold under backpressure.
    assign run        = (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign bf_valid   = run;
    assign addr_a     = run ? map_a  : '0;
    assign addr_b     = run ? map_b  : '0;
    assign tw_addr    = run ? map_tw : '0;
    assign stage      = stage_q;
    assign stage_last = run && (k_q == K_LAST);

`ifdef FFT16_AGU_INVERSE_EN
    assign tw_conj    = run && inv_q;
`endif

endmodule

// File: tb/tb_fft16_agu.sv
// Directed bench for fft16_agu: address table, full-run timing, backpressure, drain hold, mid-run reset.
module tb_fft16_agu;
    import fft16_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bf_ready = 1'b1;
    logic       pipe_empty = 1'b1;
    logic       busy, done, bf_valid, stage_last;
    logic [3:0] addr_a, addr_b;
    logic [2:0] tw_addr;
    logic [1:0] stage;
`ifdef FFT16_AGU_INVERSE_EN
    logic       inverse = 1'b0;
    logic       tw_conj;
`endif

    logic [1:0] m_stage = '0;
    logic [2:0] m_k = '0;
    logic [3:0] m_a, m_b;
    logic [2:0] m_tw;

    always #5 clk = ~clk;

    fft16_agu #(.DRAIN_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef FFT16_AGU_INVERSE_EN
        .inverse    (inverse),
        .tw_conj    (tw_conj),
`endif
        .start      (start),
        .busy       (busy),
        .done       (done),
        .bf_valid   (bf_valid),
        .bf_ready   (bf_ready),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .tw_addr    (tw_addr),
        .stage      (stage),
        .stage_last (stage_last),
        .pipe_empty (pipe_empty)
    );

    fft16_bf_addr u_map (
        .stage   (m_stage),
        .k       (m_k),
        .addr_a  (m_a),
        .addr_b  (m_b),
        .tw_addr (m_tw)
    );

    typedef struct {
        int         s;
        int         k;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] tw;
        logic       last;
    } vec_t;

    vec_t        tbl[15];
    logic [13:0] exp_d[32];
    logic [13:0] log_d[32];

    int total = 0;
    int bad   = 0;

    // run controls and results
    int rdy_lo_from, rdy_lo_to, pe_lo_from, pe_lo_to, rst_cyc, start2_cyc;
    int done_cyc, done_cnt, n_acc, busy_after, stall_cnt, conj_bad;
    int first_valid[4];

    function automatic logic [13:0] pk(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] tw, input logic last);
        return {s, a, b, tw, last};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        rdy_lo_from = -1; rdy_lo_to = -1;
        pe_lo_from  = -1; pe_lo_to  = -1;
        rst_cyc     = -1; start2_cyc = -1;
    endtask

    // Cycle 0 is the cycle in which start is presented; samples are taken 1 time unit after each edge.
    task automatic run_fft(input int max_cyc);
        logic        prev_stall;
        logic [13:0] prev_desc;
        done_cyc = -1; done_cnt = 0; n_acc = 0; busy_after = -1; stall_cnt = 0; conj_bad = 0;
        first_valid = '{-1, -1, -1, -1};
        prev_stall = 1'b0;
        prev_desc  = '0;
        for (int c = 0; c <= max_cyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            start      = (c == 0) || (c == start2_cyc);
            bf_ready   = !(c >= rdy_lo_from && c <= rdy_lo_to);
            pipe_empty = !(c >= pe_lo_from && c <= pe_lo_to);
            rst_n      = (c != rst_cyc);
`ifdef FFT16_AGU_INVERSE_EN
            inverse    = (c == 0) ? 1'b1 : 1'(c % 2);
            if (tw_conj !== bf_valid) conj_bad++;
`endif
            if (rst_cyc >= 0 && c == rst_cyc + 1)
                chk("rst_outs", {busy, done, bf_valid, addr_a, addr_b, tw_addr, stage, stage_last}, 0);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) busy_after = int'(busy);
            if (bf_valid === 1'b1 && first_valid[stage] < 0) first_valid[stage] = c;
            if (prev_stall)
                chk($sformatf("hold_c%0d", c), pk(stage, addr_a, addr_b, tw_addr, stage_last), prev_desc);
            prev_stall = bf_valid && !bf_ready;
            prev_desc  = pk(stage, addr_a, addr_b, tw_addr, stage_last);
            if (prev_stall) stall_cnt++;
            if (bf_valid && bf_ready) begin
                if (n_acc < 32) log_d[n_acc] = prev_desc;
                n_acc++;
            end
        end
        start = 1'b0; bf_ready = 1'b1; pipe_empty = 1'b1; rst_n = 1'b1;
    endtask

    task automatic chk_run(input string tag, input int exp_done, input int f1, input int f2, input int f3);
        chk({tag, ".done_cyc"}, done_cyc, exp_done);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".busy_after"}, busy_after, 0);
        chk({tag, ".first_s0"}, first_valid[0], 1);
        chk({tag, ".first_s1"}, first_valid[1], f1);
        chk({tag, ".first_s2"}, first_valid[2], f2);
        chk({tag, ".first_s3"}, first_valid[3], f3);
        chk({tag, ".n_acc"}, n_acc, 32);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s.desc%0d", tag, i), log_d[i], exp_d[i]);
`ifdef FFT16_AGU_INVERSE_EN
        chk({tag, ".tw_conj"}, conj_bad, 0);
`endif
    endtask

    initial begin
        // Expected descriptors: stage s pairs every address whose span bit is clear with address+span.
        for (int s = 0; s < 4; s++) begin
            int span, n;
            span = 8 >> s;
            n = 0;
            for (int a = 0; a < 16; a++) begin
                if ((a & span) == 0) begin
                    exp_d[s*8+n] = pk(2'(s), 4'(a), 4'(a + span), 3'(((a % span) << s) % 8), n == 7);
                    n++;
                end
            end
        end

        tbl[0]  = '{0, 0, 4'd0,  4'd8,  3'd0, 1'b0};
        tbl[1]  = '{0, 1, 4'd1,  4'd9,  3'd1, 1'b0};
        tbl[2]  = '{0, 2, 4'd2,  4'd10, 3'd2, 1'b0};
        tbl[3]  = '{0, 3, 4'd3,  4'd11, 3'd3, 1'b0};
        tbl[4]  = '{0, 4, 4'd4,  4'd12, 3'd4, 1'b0};
        tbl[5]  = '{0, 5, 4'd5,  4'd13, 3'd5, 1'b0};
        tbl[6]  = '{0, 6, 4'd6,  4'd14, 3'd6, 1'b0};
        tbl[7]  = '{0, 7, 4'd7,  4'd15, 3'd7, 1'b1};
        tbl[8]  = '{1, 0, 4'd0,  4'd4,  3'd0, 1'b0};
        tbl[9]  = '{1, 5, 4'd9,  4'd13, 3'd2, 1'b0};
        tbl[10] = '{1, 7, 4'd11, 4'd15, 3'd6, 1'b1};
        tbl[11] = '{2, 1, 4'd1,  4'd3,  3'd4, 1'b0};
        tbl[12] = '{2, 6, 4'd12, 4'd14, 3'd0, 1'b0};
        tbl[13] = '{3, 0, 4'd0,  4'd1,  3'd0, 1'b0};
        tbl[14] = '{3, 7, 4'd14, 4'd15, 3'd0, 1'b1};

        clear_ctl();

        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {busy, done, bf_valid, addr_a, addr_b, tw_addr, stage, stage_last}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_outs", {busy, done, bf_valid, addr_a, addr_b, tw_addr, stage, stage_last}, 0);

        // address map, exhaustive and against the hand table
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                m_stage = 2'(s);
                m_k     = 3'(k);
                #1;
                chk($sformatf("map_s%0d_k%0d", s, k), {m_a, m_b, m_tw}, exp_d[s*8+k][11:1]);
            end
        end
        for (int i = 0; i < 15; i++) begin
            m_stage = 2'(tbl[i].s);
            m_k     = 3'(tbl[i].k);
            #1;
            chk($sformatf("tbl_map%0d", i), {m_a, m_b, m_tw}, {tbl[i].a, tbl[i].b, tbl[i].tw});
        end

        // nominal run
        run_fft(43);
        chk_run("base", 41, 11, 21, 31);
        for (int i = 0; i < 15; i++)
            chk($sformatf("tbl_run%0d", i), log_d[tbl[i].s*8+tbl[i].k],
                pk(2'(tbl[i].s), tbl[i].a, tbl[i].b, tbl[i].tw, tbl[i].last));

        // backpressure on stage 0 k=3
        clear_ctl();
        rdy_lo_from = 4; rdy_lo_to = 6;
        run_fft(46);
        chk_run("stall", 44, 14, 24, 34);
        chk("stall.cycles", stall_cnt, 3);
        chk("stall.k3", log_d[3], pk(2'd0, 4'd3, 4'd11, 3'd3, 1'b0));

        // drain held by pipe_empty after stage 1, stray start mid-drain
        clear_ctl();
        pe_lo_from = 19; pe_lo_to = 24; start2_cyc = 21;
        run_fft(48);
        chk_run("drain", 46, 11, 26, 36);

        // reset during stage 2 run
        clear_ctl();
        rst_cyc = 23;
        run_fft(60);
        chk("rst.done_cnt", done_cnt, 0);
        chk("rst.busy_end", busy, 0);

        // restart after the abandoned transform
        clear_ctl();
        run_fft(43);
        chk_run("restart", 41, 11, 21, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
